// File: rtl/mont_exp_ctrl_if.sv
// Start/done port set between the exponentiation controller (master) and one
// Montgomery multiplier (slave).
interface mont_exp_ctrl_if #(
  parameter int WIDTH = 512
);
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_m;
  logic [WIDTH+1:0] mm_result;
  logic             mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m,
    output mm_result, mm_done
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply X^E mod M controller driving one Montgomery multiplier.
// Define MONT_EXP_FINAL_REDUCE_EN to append MM(acc,1) so the result leaves the Montgomery domain.
module mont_exp_ctrl #(
  parameter int WIDTH  = 512,
  parameter int ELEN_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  in_x_i,
  input  logic [WIDTH-1:0]  in_r_i,
  input  logic [WIDTH-1:0]  in_e_i,
  input  logic [WIDTH-1:0]  in_m_i,
  input  logic [ELEN_W-1:0] in_elen_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              done_o,
  output logic              busy_o,
  mont_exp_ctrl_if.master   mm
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ELEN_W:0] WIDTH_E = (ELEN_W+1)'(WIDTH);

`ifdef MONT_EXP_FINAL_REDUCE_EN
  typedef enum logic [3:0] {
    IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FIX_ISSUE, FIX_WAIT, DONE
  } state_e;
  localparam state_e AFTER_LAST = FIX_ISSUE;
`else
  typedef enum logic [3:0] {
    IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, DONE
  } state_e;
  localparam state_e AFTER_LAST = DONE;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   e_q, e_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [ELEN_W-1:0]  elen_q, elen_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               armed_q, armed_d;
  logic [WIDTH-1:0]   mm_a_q, mm_a_d;
  logic [WIDTH-1:0]   mm_b_q, mm_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               mm_start_c;
  logic [WIDTH-1:0]   mm_res;
  logic [ELEN_W-1:0]  elen_clamped;
  logic               unused_mm_res_hi;

  // The multiplier guarantees mm_result < M, so its two extra top bits carry nothing.
  assign mm_res           = mm.mm_result[WIDTH-1:0];
  assign unused_mm_res_hi = ^mm.mm_result[WIDTH+1:WIDTH];
  assign elen_clamped     = ({1'b0, in_elen_i} > WIDTH_E) ? WIDTH_E[ELEN_W-1:0] : in_elen_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      elen_q   <= '0;
      idx_q    <= '0;
      armed_q  <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      e_q      <= e_d;
      m_q      <= m_d;
      elen_q   <= elen_d;
      idx_q    <= idx_d;
      armed_q  <= armed_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    x_d        = x_q;
    e_d        = e_q;
    m_d        = m_q;
    elen_d     = elen_q;
    idx_d      = idx_q;
    armed_d    = armed_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    result_d   = result_q;
    mm_start_c = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          x_d     = in_x_i;
          e_d     = in_e_i;
          m_d     = in_m_i;
          elen_d  = elen_clamped;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d = in_r_i;
        if (elen_q == '0) begin
          state_d = AFTER_LAST;
        end else begin
          idx_d   = IDX_W'(elen_q - ELEN_W'(1));
          state_d = SQ_ISSUE;
        end
      end
      SQ_ISSUE: begin
        mm_start_c = 1'b1;
        state_d    = SQ_WAIT;
      end
      // A done is only trusted once it has been seen low since our own start.
      SQ_WAIT: begin
        if (armed_q && mm.mm_done) begin
          acc_d   = mm_res;
          state_d = e_q[idx_q] ? MUL_ISSUE : NEXT;
        end else if (!mm.mm_done) begin
          armed_d = 1'b1;
        end
      end
      MUL_ISSUE: begin
        mm_start_c = 1'b1;
        state_d    = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (armed_q && mm.mm_done) begin
          acc_d   = mm_res;
          state_d = NEXT;
        end else if (!mm.mm_done) begin
          armed_d = 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          state_d = AFTER_LAST;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQ_ISSUE;
        end
      end
`ifdef MONT_EXP_FINAL_REDUCE_EN
      FIX_ISSUE: begin
        mm_start_c = 1'b1;
        state_d    = FIX_WAIT;
      end
      FIX_WAIT: begin
        if (armed_q && mm.mm_done) begin
          acc_d   = mm_res;
          state_d = DONE;
        end else if (!mm.mm_done) begin
          armed_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (mm_start_c) armed_d = 1'b0;

    // Operands are loaded on entry to an ISSUE state and held through the done cycle.
    case (state_d)
      SQ_ISSUE: begin
        mm_a_d = acc_d;
        mm_b_d = acc_d;
      end
      MUL_ISSUE: begin
        mm_a_d = acc_d;
        mm_b_d = x_q;
      end
`ifdef MONT_EXP_FINAL_REDUCE_EN
      FIX_ISSUE: begin
        mm_a_d = acc_d;
        mm_b_d = WIDTH'(1);
      end
`endif
      default: ;
    endcase

    if (state_d == DONE) result_d = acc_d;
  end

  assign mm.mm_start = mm_start_c;
  assign mm.mm_a     = mm_a_q;
  assign mm.mm_b     = mm_b_q;
  assign mm.mm_m     = m_q;
  assign result_o    = result_q;
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl at WIDTH=8 with a behavioural Montgomery multiplier
// and a plain-arithmetic modular exponentiation reference.
module tb_mont_exp_ctrl;
  localparam int WIDTH  = 8;
  localparam int ELEN_W = 10;
`ifdef MONT_EXP_FINAL_REDUCE_EN
  localparam bit FINAL_REDUCE = 1'b1;
`else
  localparam bit FINAL_REDUCE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start;
  logic [WIDTH-1:0]  inX, inR, inE, inM;
  logic [ELEN_W-1:0] inElen;
  logic [WIDTH-1:0]  result;
  logic              done, busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl_if #(.WIDTH(WIDTH)) mmIf ();

  mont_exp_ctrl #(.WIDTH(WIDTH), .ELEN_W(ELEN_W)) dut (
    .clk(clk), .reset(reset), .start_i(start),
    .in_x_i(inX), .in_r_i(inR), .in_e_i(inE), .in_m_i(inM), .in_elen_i(inElen),
    .result_o(result), .done_o(done), .busy_o(busy),
    .mm(mmIf)
  );

  // Montgomery product a*b*R^-1 mod m by bitwise REDC, fully reduced below m.
  function automatic int mont(int a, int b, int m);
    int t = a * b;
    for (int i = 0; i < WIDTH; i++) begin
      if (t % 2 == 1) t = t + m;
      t = t / 2;
    end
    if (t >= m) t = t - m;
    return t;
  endfunction

  // Behavioural multiplier: done rises Tmm cycles after the start cycle; in hold
  // mode it stays high (with the old result) until one cycle after the next start.
  int              tmm = 3;
  bit              holdMode = 1'b0;
  int              rem = 0;
  bit              inFlight = 1'b0;
  bit              endOfOp = 1'b0;
  bit              dropPending = 1'b0;
  logic [WIDTH-1:0] capA, capB;
  int              pulses = 0;
  int              stabErr = 0;

  always @(posedge clk) begin
    if (reset) begin
      rem              <= 0;
      inFlight         <= 1'b0;
      endOfOp          <= 1'b0;
      dropPending      <= 1'b0;
      mmIf.mm_done     <= 1'b0;
      mmIf.mm_result   <= '0;
    end else begin
      if (inFlight && (mmIf.mm_a !== capA || mmIf.mm_b !== capB)) stabErr <= stabErr + 1;
      if (endOfOp) begin
        inFlight <= 1'b0;
        endOfOp  <= 1'b0;
        if (!holdMode) mmIf.mm_done <= 1'b0;
      end
      if (dropPending) begin
        dropPending  <= 1'b0;
        mmIf.mm_done <= 1'b0;
      end
      if (mmIf.mm_start) begin
        pulses      <= pulses + 1;
        capA        <= mmIf.mm_a;
        capB        <= mmIf.mm_b;
        rem         <= tmm - 1;
        inFlight    <= 1'b1;
        dropPending <= holdMode;
        if (!holdMode) mmIf.mm_done <= 1'b0;
      end else if (rem > 0) begin
        if (rem == 1) begin
          mmIf.mm_done   <= 1'b1;
          mmIf.mm_result <= (WIDTH+2)'(mont(int'(capA), int'(capB), int'(mmIf.mm_m)));
          endOfOp        <= 1'b1;
        end
        rem <= rem - 1;
      end
    end
  end

  // Reference model: ordinary modular arithmetic on the decoded base.
  function automatic int clampElen(int elen);
    return (elen > WIDTH) ? WIDTH : elen;
  endfunction

  function automatic int expectResult(int x, int e, int m, int elen);
    int ec = clampElen(elen);
    int rinv = 0;
    int base, y;
    for (int k = 1; k < m; k++) if (((1 << WIDTH) * k) % m == 1) rinv = k;
    base = (x * rinv) % m;
    y = 1;
    for (int i = 0; i < ec; i++) begin
      if (((e >> i) & 1) == 1) y = (y * base) % m;
      base = (base * base) % m;
    end
    return FINAL_REDUCE ? y : (y * (1 << WIDTH)) % m;
  endfunction

  function automatic int expectPulses(int e, int elen);
    int ec = clampElen(elen);
    int n = ec + (FINAL_REDUCE ? 1 : 0);
    for (int i = 0; i < ec; i++) n += (e >> i) & 1;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int e, input int m, input int r, input int elen);
    @(negedge clk);
    inX    = WIDTH'(x);
    inE    = WIDTH'(e);
    inM    = WIDTH'(m);
    inR    = WIDTH'(r);
    inElen = ELEN_W'(elen);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n is the cycle (start sampled at cycle 0) in which done is first seen.
  task automatic waitDone(output int n, output int timedOut);
    n = 1;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    timedOut = done ? 0 : 1;
  endtask

  task automatic waitPulses(input int target, input int p0);
    int cnt = 0;
    while (pulses - p0 < target && cnt < 500) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic runCase(input string name, input int x, input int e, input int m, input int r,
                         input int elen, input int expRes, input int expPulses, input int expCycles);
    int p0, s0, n, to;
    p0 = pulses;
    s0 = stabErr;
    applyStimulus(x, e, m, r, elen);
    waitDone(n, to);
    checkOutput({name, " timeout"}, to, 0);
    checkOutput({name, " result"}, int'(result), expRes);
    checkOutput({name, " mm_start count"}, pulses - p0, expPulses);
    checkOutput({name, " done cycle"}, n, expCycles);
    checkOutput({name, " operand stability"}, stabErr - s0, 0);
    checkOutput({name, " busy in done"}, int'(busy), 0);
    checkOutput({name, " mm_m"}, int'(mmIf.mm_m), m);
  endtask

  typedef struct {
    int x, e, m, r, elen;
    int expRes, expPulses, expCycles;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int p0, n, to;
    int m, x, e, elen, r;

    vecs[0] = '{5, 5,   13, 9, 3,   FINAL_REDUCE ? 6 : 2, FINAL_REDUCE ? 6  : 5,  FINAL_REDUCE ? 29 : 25};
    vecs[1] = '{5, 5,   13, 9, 0,   FINAL_REDUCE ? 1 : 9, FINAL_REDUCE ? 1  : 0,  FINAL_REDUCE ? 6  : 2};
    vecs[2] = '{5, 255, 13, 9, 600, FINAL_REDUCE ? 8 : 7, FINAL_REDUCE ? 17 : 16, FINAL_REDUCE ? 78 : 74};

    start = 1'b0; inX = '0; inR = '0; inE = '0; inM = '0; inElen = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result", int'(result), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset mm_start", int'(mmIf.mm_start), 0);
    checkOutput("reset mm_a", int'(mmIf.mm_a), 0);
    checkOutput("reset mm_b", int'(mmIf.mm_b), 0);
    checkOutput("reset mm_m", int'(mmIf.mm_m), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++)
      runCase($sformatf("vec%0d", i), vecs[i].x, vecs[i].e, vecs[i].m, vecs[i].r, vecs[i].elen,
              vecs[i].expRes, vecs[i].expPulses, vecs[i].expCycles);

    // Multiplier that leaves a stale done asserted past the next start.
    holdMode = 1'b1;
    tmm = 5;
    runCase("hold-done", 5, 5, 13, 9, 3, FINAL_REDUCE ? 6 : 2, FINAL_REDUCE ? 6 : 5,
            FINAL_REDUCE ? 41 : 35);
    holdMode = 1'b0;
    tmm = 3;

    // A second start during MUL_WAIT must be ignored.
    p0 = pulses;
    applyStimulus(5, 5, 13, 9, 3);
    waitPulses(2, p0);
    checkOutput("busy-start reached mul", pulses - p0, 2);
    applyStimulus(7, 3, 11, 3, 2);
    waitDone(n, to);
    checkOutput("busy-start timeout", to, 0);
    checkOutput("busy-start result", int'(result), FINAL_REDUCE ? 6 : 2);
    checkOutput("busy-start mm_start count", pulses - p0, FINAL_REDUCE ? 6 : 5);
    checkOutput("busy-start mm_m", int'(mmIf.mm_m), 13);

    // Reset during the square of the second exponent bit.
    p0 = pulses;
    applyStimulus(5, 5, 13, 9, 3);
    waitPulses(3, p0);
    checkOutput("abort reached sq2", pulses - p0, 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort mm_start", int'(mmIf.mm_start), 0);
    checkOutput("abort result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    runCase("post-abort", 5, 5, 13, 9, 3, FINAL_REDUCE ? 6 : 2, FINAL_REDUCE ? 6 : 5,
            FINAL_REDUCE ? 29 : 25);

    for (int t = 0; t < 20; t++) begin
      m        = 2 * int'($urandom_range(1, 127)) + 1;
      x        = int'($urandom_range(0, m - 1));
      e        = int'($urandom_range(0, 255));
      elen     = int'($urandom_range(0, 12));
      r        = (1 << WIDTH) % m;
      holdMode = 1'($urandom_range(0, 1));
      tmm      = int'($urandom_range(3, 6));
      runCase($sformatf("rand%0d", t), x, e, m, r, elen, expectResult(x, e, m, elen),
              expectPulses(e, elen),
              2 + expectPulses(e, elen) * (tmm + 1) + clampElen(elen));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Left-to-right square-and-multiply modular exponentiation controller for the RSA datapath. It initiates Montgomery multiplications on an external multiplier through that multiplier's start/done port set: it drives operands and a start pulse, then consumes the result and done. The result is X^E mod M. The X input and the internal accumulator are in Montgomery form (R = 2^WIDTH). Sits between the host-facing register interface and one Montgomery multiplier instance.

## Interface
- WIDTH, 512, operand width; R = 2^WIDTH
- ELEN_W, 10, width of the exponent-length field
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- in_x  in  WIDTH  base in Montgomery form (x·R mod M)
- in_r  in  WIDTH  R mod M (Montgomery one)
- in_e  in  WIDTH  exponent
- in_m  in  WIDTH  odd modulus
- in_elen  in  ELEN_W  number of exponent bits to process; values > WIDTH are clamped to WIDTH
- result  out  WIDTH  exponentiation result
- done  out  1  high in DONE until the next accepted start or reset
- busy  out  1  high in every state except IDLE and DONE
- mm_start  out  1  one-cycle start to the multiplier
- mm_a, mm_b, mm_m  out  WIDTH  multiplier operands; registered
- mm_result  in  WIDTH+2  multiplier output
- mm_done  in  1  multiplier completion; level

## Operation
- States: IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FIX_ISSUE, FIX_WAIT, DONE.
- IDLE/DONE + start: latch in_x, in_e, in_m and clamped in_elen. Clear done. Go to LOAD.
- LOAD:
  - acc ← in_r.
  - If elen = 0, go to FIX_ISSUE (macro on) or DONE (macro off).
  - Otherwise idx ← elen−1 and go to SQ_ISSUE.
- SQ_ISSUE: mm_a = mm_b = acc, mm_start = 1, go to SQ_WAIT.
- SQ_WAIT: on mm_done while armed, acc ← mm_result[WIDTH-1:0]. Then go to MUL_ISSUE if e[idx] = 1, else NEXT.
- MUL_ISSUE: mm_a = acc, mm_b = x, mm_start = 1, go to MUL_WAIT.
- MUL_WAIT: on mm_done while armed, acc ← mm_result[WIDTH-1:0], go to NEXT.
- NEXT:
  - If idx = 0, go to FIX_ISSUE (macro on) or DONE.
  - Otherwise idx ← idx−1 and go to SQ_ISSUE.
- FIX_ISSUE / FIX_WAIT: mm_a = acc, mm_b = 1. Same handshake. Result goes to acc, then DONE.
- DONE: result = acc, done = 1. Holds until an accepted start.
- Armed flag:
  - Cleared when mm_start pulses.
  - Set when mm_done is sampled low in a WAIT state.
  - mm_done is ignored while not armed, so a stale done held from the previous op is never consumed.
- mm_m = latched m at all times after LOAD.
- mm_a and mm_b are stable from the ISSUE cycle through the done cycle.
- The upper two bits of mm_result are discarded. The multiplier guarantees mm_result < M.
- start while busy is ignored. Latched operands are unaffected.

## Timing
- Reset values: result = 0, done = 0, busy = 0, mm_start = 0, mm_a = mm_b = mm_m = 0, state = IDLE. Reset mid-operation aborts immediately, and mm_start is low the following cycle.
- mm_start is high for exactly one cycle per multiplication.
- Tmm is the cycle offset from the mm_start-high cycle to the cycle in which mm_done is sampled high.
- Each multiplication occupies Tmm+1 cycles.
- N = elen + popcount(e[elen-1:0]), plus 1 with the macro on.
- Start is sampled at cycle 0. DONE is entered at cycle 2 + N·(Tmm+1) + elen.
- With elen = 0 and the macro off, DONE is entered at cycle 2.

## Configuration
- MONT_EXP_FINAL_REDUCE_EN defined:
  - A final MM(acc, 1) runs after the last exponent bit, including when elen = 0.
  - result is ordinary-domain X^E mod M.
- MONT_EXP_FINAL_REDUCE_EN undefined:
  - FIX states are not compiled.
  - result is in Montgomery form (X^E·R mod M). The host performs the conversion.

## Test plan
- WIDTH=8, M=13, in_r=9, in_x=5 (x=2), e=5, elen=3, behavioural multiplier with Tmm=3:
  - Macro on: result = 6, 6 mm_start pulses, done at cycle 29.
  - Macro off: result = 2, 5 pulses, done at cycle 25.
- elen=0, same operands:
  - Macro on: result = 1.
  - Macro off: result = 9, done at cycle 2, no mm_start.
- Multiplier model holds mm_done high until its next start, with Tmm=5:
  - No acc update in the cycle after any mm_start.
  - Results match the first scenario.
- start pulsed during MUL_WAIT with different operands: ignored, and the first scenario's result is unchanged.
- reset asserted during SQ_WAIT of the second bit: next cycle state = IDLE, busy = 0, done = 0, mm_start = 0. A new start then completes correctly.
- e = 2^WIDTH−1, elen = 600: clamped to 8, with exactly 16 (+1) multiplications.
